adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester lanes sharing one adder (2..8).
REQ-002 Parameter ID_W, default 2, lane-ID width, equal to clog2(NUM_REQ).
REQ-003 iClk  input  1  sole clock, rising edge.
REQ-004 iRst  input  1  asynchronous, active-high reset.
REQ-005 iReqValid  input  NUM_REQ  per-lane beat valid.
REQ-006 oReqReady  output  NUM_REQ  per-lane beat ready.
REQ-007 iReqLast  input  NUM_REQ  per-lane end-of-frame.
REQ-008 iReqData  input  NUM_REQ*16  per-lane Q0.16 exp value; lane k occupies bits [16k+15:16k].
REQ-009 oAddValid / iAddReady / oAddLast / oAddData[15:0]  out/in/out/out  stream into the shared adder.
REQ-010 iSumValid / oSumReady / iSumData[15:0]  in/out/in  Q5.11 frame sum returned by the adder.
REQ-011 oResValid / iResReady / oResData[15:0] / oResId[ID_W-1:0]  out/in/out/out  tagged result to downstream.
REQ-012 iCfgMaxLen  input  16  maximum beats per frame; 0 means unlimited.
REQ-013 oErrLen  output  NUM_REQ  sticky per-lane frame-overlength flag.
REQ-014 iErrClr  input  1  clears all oErrLen bits.
REQ-015 oBusy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, STREAM, WAIT_SUM, RESULT; one frame in flight at a time.
REQ-017 IDLE: when any iReqValid is high, a round-robin pick SHALL register the grant and enter STREAM next cycle; the pick order starts at the lane after the last granted lane (lane 0 after reset).
REQ-018 STREAM: oAddValid = iReqValid[g], oAddData = lane g data, oReqReady[g] = iAddReady; all other oReqReady bits SHALL be 0.
REQ-019 Grant SHALL stay locked to lane g until a fired beat with oAddLast=1; other lanes' requests SHALL NOT preempt.
REQ-020 A 16-bit beat counter SHALL reset to 0 on grant and increment on each fired beat.
REQ-021 oAddLast = iReqLast[g] OR (iCfgMaxLen!=0 AND count==iCfgMaxLen-1).
REQ-022 A forced last (counter term true, iReqLast[g] low) SHALL set oErrLen[g]; the lane's subsequent beats form a new frame.
REQ-023 Fired beat with oAddLast=1 SHALL move the FSM to WAIT_SUM.
REQ-024 WAIT_SUM: oSumReady=1; oSumReady SHALL be 0 in all other states. On iSumValid, capture iSumData into oResData and g into oResId, then go to RESULT.
REQ-025 RESULT: oResValid=1, data/ID held stable; on iResReady, go to IDLE and update the round-robin pointer to g.
REQ-026 IDLE-to-next-grant turnaround SHALL be exactly 1 cycle after result acceptance; minimum overhead is 3 cycles per frame beyond the beats.
REQ-027 Simultaneous iErrClr and a set event on the same lane: set SHALL win.
REQ-028 iCfgMaxLen SHALL be sampled continuously; changing it mid-frame is legal and takes effect on the next beat compare.
REQ-029 Data SHALL pass unmodified; no arithmetic on payload.

Reset
REQ-030 On iRst: state=IDLE, pointer=0, counter=0, oErrLen=0, oResData=0, oResId=0.
REQ-031 After iRst, all outputs SHALL be low, and oAddValid SHALL be 0 from the first cycle after assertion.
REQ-032 iRst mid-frame SHALL abandon the frame; the adder SHALL be reset on the same reset to clear its partial sum.

Structure
REQ-033 Package softmax_pkg SHALL hold DATA_W=16, Q-format constants, the FSM state encoding and the NUM_REQ default.
REQ-034 Round-robin picker SHALL be a sub-module rr_arbiter (request vector plus pointer in, one-hot grant out, combinational).

Verification
REQ-035 Lane 1 sends frame {0x8000,0x8000} -> adder sees 2 beats, last on the 2nd; oResId=1 with the adder's sum 0x0800.
REQ-036 All 4 lanes request continuously -> grant order 0,1,2,3,0; no beat from a non-granted lane reaches the adder.
REQ-037 iCfgMaxLen=3, lane 2 sends 5 beats with last on the 5th -> forced last on beat 3, oErrLen=0b0100, and beats 4-5 form a second frame.
REQ-038 iResReady held low for 10 cycles -> oResValid, oResData and oResId are stable, no new grant occurs, and oReqReady=0.
REQ-039 iRst pulsed during STREAM beat 2 -> next cycle state=IDLE, oAddValid=0; the next frame sums only its own beats.
REQ-040 iErrClr and a forced last on the same cycle and lane -> oErrLen bit remains 1.

Source files
------------

// File: rtl/softmax_pkg.sv
// softmax_pkg
// Shared constants for the softmax adder-arbiter slice: payload width,
// fixed-point formats of the exp inputs (Q0.16) and of the frame sums
// returned by the adder (Q5.11), the default lane count, and the arbiter
// FSM state encoding.
package softmax_pkg;

  localparam int DATA_W      = 16;  // beat and sum payload width
  localparam int NUM_REQ_DEF = 4;   // default number of requester lanes

  // Q-format of the per-lane exp values (unsigned fraction only)
  localparam int EXP_Q_INT  = 0;
  localparam int EXP_Q_FRAC = 16;

  // Q-format of the frame sum produced by the shared adder
  localparam int SUM_Q_INT  = 5;
  localparam int SUM_Q_FRAC = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_SUM = 2'd2,
    ST_RESULT   = 2'd3
  } state_e;

  // Lane index following idx, wrapping at num (num need not be a power of two)
  function automatic int lane_after(input int idx, input int num);
    if (idx + 1 >= num) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. Scans the request vector starting at
// lane iPtr and wrapping, and grants the first requesting lane.
//   iReq  [NUM_REQ-1:0]  request per lane
//   iPtr  [ID_W-1:0]     lane at which the scan starts
//   oGnt  [NUM_REQ-1:0]  one-hot grant, all zero when nothing requests
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [ID_W-1:0]    iPtr,
  output logic [NUM_REQ-1:0] oGnt
);

  logic w_found;
  int   w_idx;

  // first requesting lane at or after iPtr wins
  always_comb begin
    oGnt    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(iPtr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && iReq[w_idx]) begin
        oGnt[w_idx] = 1'b1;
        w_found     = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Shares one streaming adder between NUM_REQ requester lanes. One frame is
// in flight at a time: a lane is granted round-robin, its beats are passed
// unmodified to the adder until a last beat, the adder's Q5.11 sum is
// captured and presented downstream tagged with the lane ID.
//   iClk, iRst                        clock, async active-high reset
//   iReqValid/oReqReady/iReqLast      per-lane beat handshake and end-of-frame
//   iReqData                          per-lane Q0.16 data, lane k at [16k+15:16k]
//   oAddValid/iAddReady/oAddLast/oAddData   beat stream into the adder
//   iSumValid/oSumReady/iSumData      frame sum from the adder
//   oResValid/iResReady/oResData/oResId     tagged result downstream
//   iCfgMaxLen                        max beats per frame, 0 = unlimited
//   oErrLen, iErrClr                  sticky per-lane overlength flags, clear
//   oBusy                             FSM not idle
module adder_arbiter
  import softmax_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = 2
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [NUM_REQ-1:0]           iReqValid,
  output logic [NUM_REQ-1:0]           oReqReady,
  input  logic [NUM_REQ-1:0]           iReqLast,
  input  logic [NUM_REQ*EXP_Q_FRAC-1:0] iReqData,
  output logic                         oAddValid,
  input  logic                         iAddReady,
  output logic                         oAddLast,
  output logic [DATA_W-1:0]            oAddData,
  input  logic                         iSumValid,
  output logic                         oSumReady,
  input  logic [SUM_Q_INT+SUM_Q_FRAC-1:0] iSumData,
  output logic                         oResValid,
  input  logic                         iResReady,
  output logic [DATA_W-1:0]            oResData,
  output logic [ID_W-1:0]              oResId,
  input  logic [15:0]                  iCfgMaxLen,
  output logic [NUM_REQ-1:0]           oErrLen,
  input  logic                         iErrClr,
  output logic                         oBusy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ID_W-1:0]     r_gnt_id;
  logic [ID_W-1:0]     r_start;
  logic [ID_W-1:0]     r_res_id;
  logic [DATA_W-1:0]   r_res_data;
  logic [15:0]         r_cnt;
  logic [NUM_REQ-1:0]  r_err_len;

  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [ID_W-1:0]     w_pick_id;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [NUM_REQ-1:0]  w_err_set;
  logic                w_any_req;
  logic                w_lane_valid;
  logic                w_lane_last;
  logic [DATA_W-1:0]   w_lane_data;
  logic                w_cnt_last;
  logic                w_last;
  logic                w_fire;

  assign w_any_req = |iReqValid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .iReq (iReqValid),
    .iPtr (r_start),
    .oGnt (w_pick_oh)
  );

  // one-hot pick to lane index
  always_comb begin
    w_pick_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_oh[k]) begin
        w_pick_id = ID_W'(k);
      end else begin
        w_pick_id = w_pick_id;
      end
    end
  end

  // select the granted lane's valid/last/data and decode the grant
  always_comb begin
    w_lane_valid = 1'b0;
    w_lane_last  = 1'b0;
    w_lane_data  = '0;
    w_gnt_oh     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == r_gnt_id) begin
        w_lane_valid = iReqValid[k];
        w_lane_last  = iReqLast[k];
        w_lane_data  = iReqData[k*EXP_Q_FRAC +: EXP_Q_FRAC];
        w_gnt_oh[k]  = 1'b1;
      end else begin
        w_gnt_oh[k] = 1'b0;
      end
    end
  end

  // the counter term forces a last once the frame reaches iCfgMaxLen beats
  assign w_cnt_last = (iCfgMaxLen != 16'd0) && (r_cnt == iCfgMaxLen - 16'd1);
  assign w_last     = w_lane_last | w_cnt_last;
  assign w_fire     = (r_state == ST_STREAM) && w_lane_valid && iAddReady;

  // overlength flag set only when the lane itself did not mark the last beat
  always_comb begin
    w_err_set = '0;
    if (w_fire && w_cnt_last && !w_lane_last) begin
      w_err_set = w_gnt_oh;
    end else begin
      w_err_set = '0;
    end
  end

  // FSM state register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_fire && w_last) begin
          w_state_nxt = ST_WAIT_SUM;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_WAIT_SUM: begin
        if (iSumValid) begin
          w_state_nxt = ST_RESULT;
        end else begin
          w_state_nxt = ST_WAIT_SUM;
        end
      end
      ST_RESULT: begin
        if (iResReady) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESULT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: only the granted lane sees ready, and only while streaming
  always_comb begin
    oAddValid = 1'b0;
    oAddLast  = 1'b0;
    oAddData  = '0;
    oReqReady = '0;
    oSumReady = 1'b0;
    oResValid = 1'b0;
    case (r_state)
      ST_STREAM: begin
        oAddValid = w_lane_valid;
        oAddLast  = w_last;
        oAddData  = w_lane_data;
        oReqReady = w_gnt_oh & {NUM_REQ{iAddReady}};
      end
      ST_WAIT_SUM: begin
        oSumReady = 1'b1;
      end
      ST_RESULT: begin
        oResValid = 1'b1;
      end
      default: begin
        oAddValid = 1'b0;
      end
    endcase
  end

  // grant, beat counter, captured result and round-robin start lane
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_gnt_id   <= '0;
      r_start    <= '0;
      r_cnt      <= 16'd0;
      r_res_data <= '0;
      r_res_id   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt_id <= w_pick_id;
            r_cnt    <= 16'd0;
          end
        end
        ST_STREAM: begin
          if (w_fire) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_WAIT_SUM: begin
          if (iSumValid) begin
            r_res_data <= iSumData;
            r_res_id   <= r_gnt_id;
          end
        end
        ST_RESULT: begin
          // next scan starts just after the lane that was served
          if (iResReady) begin
            r_start <= ID_W'(lane_after(int'(r_gnt_id), NUM_REQ));
          end
        end
        default: begin
          r_cnt <= 16'd0;
        end
      endcase
    end
  end

  // sticky overlength flags; a set on the same cycle as a clear wins
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_err_len <= '0;
    end else begin
      r_err_len <= (r_err_len & ~{NUM_REQ{iErrClr}}) | w_err_set;
    end
  end

  assign oErrLen  = r_err_len;
  assign oResData = r_res_data;
  assign oResId   = r_res_id;
  assign oBusy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int NR = 4;

  logic          clk;
  logic          iRst;
  logic [NR-1:0] iReqValid;
  logic [NR-1:0] oReqReady;
  logic [NR-1:0] iReqLast;
  logic [NR*16-1:0] iReqData;
  logic          oAddValid;
  logic          iAddReady;
  logic          oAddLast;
  logic [15:0]   oAddData;
  logic          iSumValid;
  logic          oSumReady;
  logic [15:0]   iSumData;
  logic          oResValid;
  logic          iResReady;
  logic [15:0]   oResData;
  logic [1:0]    oResId;
  logic [15:0]   iCfgMaxLen;
  logic [NR-1:0] oErrLen;
  logic          iErrClr;
  logic          oBusy;

  adder_arbiter dut (
    .iClk(clk), .iRst(iRst),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqLast(iReqLast), .iReqData(iReqData),
    .oAddValid(oAddValid), .iAddReady(iAddReady), .oAddLast(oAddLast), .oAddData(oAddData),
    .iSumValid(iSumValid), .oSumReady(oSumReady), .iSumData(iSumData),
    .oResValid(oResValid), .iResReady(iResReady), .oResData(oResData), .oResId(oResId),
    .iCfgMaxLen(iCfgMaxLen), .oErrLen(oErrLen), .iErrClr(iErrClr), .oBusy(oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counters: n_* stepped by the main sequence, m_* by the result monitor
  int n_chk = 0, n_pass = 0, m_chk = 0, m_pass = 0;

  // per-lane beat FIFOs {last,data}: written by the sequence, read by the driver
  logic [16:0] lane_mem [NR][16];
  int lane_wr [NR];
  int lane_rd [NR];

  // expected results {id,data}: pushed by the sequence, popped by the monitor
  logic [17:0] sb_mem [32];
  int sb_wr = 0, sb_rd = 0;

  // frame lengths seen by the adder model
  int fl_mem [64];
  int fl_wr = 0, fl_rd = 0;

  // adder model state
  logic [31:0] acc;
  int          cur_len;
  logic        sum_v;
  logic [15:0] sum_d;
  logic [NR-1:0] lane_fire;
  logic        add_fire, add_last, sum_fire;
  logic [15:0] add_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_beat(input int k, input logic [15:0] d, input logic l);
    lane_mem[k][lane_wr[k] % 16] = {l, d};
    lane_wr[k]++;
  endtask

  task automatic expect_res(input logic [1:0] id, input logic [15:0] d);
    sb_mem[sb_wr % 32] = {id, d};
    sb_wr++;
  endtask

  function automatic bit all_idle();
    bit e = 1'b1;
    for (int k = 0; k < NR; k++) if (lane_rd[k] != lane_wr[k]) e = 1'b0;
    return e && (sb_rd == sb_wr) && !oBusy && !iSumValid;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!all_idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, all_idle()}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    iRst = 1'b1;
    for (int k = 0; k < NR; k++) lane_wr[k] = lane_rd[k];
    @(negedge clk);
    iRst = 1'b0;
    fl_rd = fl_wr;
  endtask

  // lane drivers plus adder model; decisions sampled on the falling edge
  initial begin
    acc = 32'd0; cur_len = 0; sum_v = 1'b0; sum_d = 16'd0;
    iReqValid = '0; iReqLast = '0; iReqData = '0; iSumValid = 1'b0; iSumData = 16'd0;
    for (int k = 0; k < NR; k++) lane_rd[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) lane_fire[k] = iReqValid[k] & oReqReady[k];
      add_fire = oAddValid & iAddReady;
      add_data = oAddData;
      add_last = oAddLast;
      sum_fire = iSumValid & oSumReady;
      @(posedge clk);
      #1;
      if (iRst) begin
        acc = 32'd0; cur_len = 0; sum_v = 1'b0;
      end else begin
        for (int k = 0; k < NR; k++) if (lane_fire[k]) lane_rd[k]++;
        if (sum_fire) sum_v = 1'b0;
        if (add_fire) begin
          acc = acc + {16'd0, add_data};
          cur_len++;
          if (add_last) begin
            sum_d = acc[20:5];   // Q0.16 sum to Q5.11
            sum_v = 1'b1;
            fl_mem[fl_wr % 64] = cur_len;
            fl_wr++;
            acc = 32'd0;
            cur_len = 0;
          end
        end
      end
      for (int k = 0; k < NR; k++) begin
        if (lane_rd[k] != lane_wr[k]) begin
          iReqValid[k] = 1'b1;
          iReqLast[k]  = lane_mem[k][lane_rd[k] % 16][16];
          iReqData[16*k +: 16] = lane_mem[k][lane_rd[k] % 16][15:0];
        end else begin
          iReqValid[k] = 1'b0;
          iReqLast[k]  = 1'b0;
          iReqData[16*k +: 16] = 16'd0;
        end
      end
      iSumValid = sum_v;
      iSumData  = sum_d;
    end
  end

  // result monitor: pops the scoreboard whenever a result is accepted
  always @(negedge clk) begin
    if (!iRst && oResValid && iResReady) begin
      m_chk++;
      if (sb_rd == sb_wr) begin
        $display("FAIL result: unexpected id=%0d data=0x%0h", oResId, oResData);
      end else begin
        if ({oResId, oResData} === sb_mem[sb_rd % 32]) m_pass++;
        else $display("FAIL result: got id=%0d data=0x%0h, expected id=%0d data=0x%0h",
                      oResId, oResData, sb_mem[sb_rd % 32][17:16], sb_mem[sb_rd % 32][15:0]);
        sb_rd++;
      end
    end
  end

  initial begin
    bit found;
    int n;
    iRst = 1'b1; iAddReady = 1'b1; iResReady = 1'b1; iCfgMaxLen = 16'd0; iErrClr = 1'b0;
    for (int k = 0; k < NR; k++) lane_wr[k] = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_addvalid", {31'd0, oAddValid}, 32'd0);
    check("rst_addlast",  {31'd0, oAddLast}, 32'd0);
    check("rst_adddata",  {16'd0, oAddData}, 32'd0);
    check("rst_reqready", {28'd0, oReqReady}, 32'd0);
    check("rst_sumready", {31'd0, oSumReady}, 32'd0);
    check("rst_resvalid", {31'd0, oResValid}, 32'd0);
    check("rst_resdata",  {16'd0, oResData}, 32'd0);
    check("rst_resid",    {30'd0, oResId}, 32'd0);
    check("rst_errlen",   {28'd0, oErrLen}, 32'd0);
    check("rst_busy",     {31'd0, oBusy}, 32'd0);
    @(negedge clk);
    iRst = 1'b0;

    // lane 1: two 0.5 beats -> sum 1.0 in Q5.11
    push_beat(1, 16'h8000, 1'b0);
    push_beat(1, 16'h8000, 1'b1);
    expect_res(2'd1, 16'h0800);
    wait_done("t1_done", 100);
    check("t1_frames", fl_wr - fl_rd, 32'd1);
    check("t1_len", fl_mem[fl_rd % 64], 32'd2);
    fl_rd = fl_wr;

    // all lanes requesting: round-robin order 0,1,2,3,0,1,2,3 from reset
    pulse_reset();
    push_beat(0, 16'h1000, 1'b0); push_beat(0, 16'h1000, 1'b1);
    push_beat(0, 16'h2000, 1'b0); push_beat(0, 16'h2000, 1'b1);
    push_beat(1, 16'h1100, 1'b0); push_beat(1, 16'h1100, 1'b1);
    push_beat(1, 16'h2100, 1'b0); push_beat(1, 16'h2100, 1'b1);
    push_beat(2, 16'h1200, 1'b0); push_beat(2, 16'h1200, 1'b1);
    push_beat(2, 16'h2200, 1'b0); push_beat(2, 16'h2200, 1'b1);
    push_beat(3, 16'h1300, 1'b0); push_beat(3, 16'h1300, 1'b1);
    push_beat(3, 16'h2300, 1'b0); push_beat(3, 16'h2300, 1'b1);
    expect_res(2'd0, 16'h0100); expect_res(2'd1, 16'h0110);
    expect_res(2'd2, 16'h0120); expect_res(2'd3, 16'h0130);
    expect_res(2'd0, 16'h0200); expect_res(2'd1, 16'h0210);
    expect_res(2'd2, 16'h0220); expect_res(2'd3, 16'h0230);
    wait_done("t2_done", 400);
    check("t2_frames", fl_wr - fl_rd, 32'd8);
    fl_rd = fl_wr;

    // max length 3, lane 2 sends 5 beats: forced last on beat 3
    iCfgMaxLen = 16'd3;
    push_beat(2, 16'h0100, 1'b0); push_beat(2, 16'h0200, 1'b0);
    push_beat(2, 16'h0300, 1'b0); push_beat(2, 16'h0400, 1'b0);
    push_beat(2, 16'h0500, 1'b1);
    expect_res(2'd2, 16'h0030);
    expect_res(2'd2, 16'h0048);
    wait_done("t3_done", 200);
    check("t3_errlen", {28'd0, oErrLen}, 32'h4);
    check("t3_frames", fl_wr - fl_rd, 32'd2);
    check("t3_len1", fl_mem[fl_rd % 64], 32'd3);
    check("t3_len2", fl_mem[(fl_rd + 1) % 64], 32'd2);
    fl_rd = fl_wr;
    iCfgMaxLen = 16'd0;

    // downstream stall: result held, no new grant while lane 3 waits
    iResReady = 1'b0;
    push_beat(0, 16'h4000, 1'b1);
    expect_res(2'd0, 16'h0200);
    n = 0;
    while (!oResValid && n < 50) begin @(negedge clk); n++; end
    check("t4_resvalid", {31'd0, oResValid}, 32'd1);
    push_beat(3, 16'h0800, 1'b1);
    expect_res(2'd3, 16'h0040);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check("t4_hold", {7'd0, oResValid, oResId, oResData, oReqReady, oAddValid, oBusy},
            {7'd0, 1'b1, 2'd0, 16'h0200, 4'b0000, 1'b0, 1'b1});
      @(negedge clk);
    end
    @(posedge clk); #1;
    iResReady = 1'b1;
    wait_done("t4_done", 100);

    // reset during beat 2 of a lane-1 frame abandons it
    pulse_reset();
    push_beat(1, 16'h1000, 1'b0); push_beat(1, 16'h2000, 1'b0); push_beat(1, 16'h3000, 1'b1);
    found = 1'b0; n = 0;
    while (!found && n < 50) begin
      @(negedge clk);
      found = oAddValid && oReqReady[1] && (cur_len == 1);
      n++;
    end
    check("t5_beat2", {31'd0, found}, 32'd1);
    iRst = 1'b1;
    for (int k = 0; k < NR; k++) lane_wr[k] = lane_rd[k];
    @(negedge clk);
    check("t5_busy", {31'd0, oBusy}, 32'd0);
    check("t5_addvalid", {31'd0, oAddValid}, 32'd0);
    check("t5_errlen", {28'd0, oErrLen}, 32'd0);
    iRst = 1'b0;
    fl_rd = fl_wr;
    push_beat(1, 16'h0400, 1'b0); push_beat(1, 16'h0400, 1'b1);
    expect_res(2'd1, 16'h0040);
    wait_done("t5_done", 100);

    // clear and forced-last set on the same cycle: set wins
    iCfgMaxLen = 16'd2;
    push_beat(0, 16'h0100, 1'b0); push_beat(0, 16'h0100, 1'b0); push_beat(0, 16'h0200, 1'b1);
    expect_res(2'd0, 16'h0010);
    expect_res(2'd0, 16'h0010);
    found = 1'b0; n = 0;
    while (!found && n < 50) begin
      @(negedge clk);
      found = oAddValid && oAddLast && oReqReady[0];
      n++;
    end
    check("t6_forced", {31'd0, found}, 32'd1);
    iErrClr = 1'b1;
    @(posedge clk); #1;
    iErrClr = 1'b0;
    @(negedge clk);
    check("t6_setwins", {28'd0, oErrLen}, 32'h1);
    wait_done("t6_done", 100);
    iCfgMaxLen = 16'd0;
    iErrClr = 1'b1;
    @(negedge clk);
    iErrClr = 1'b0;
    @(negedge clk);
    check("t6_clear", {28'd0, oErrLen}, 32'h0);
    check("sb_empty", sb_wr - sb_rd, 32'd0);

    n_pass += m_pass;
    n_chk  += m_chk;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
